// File: rtl/digitaler_filter_pkg.sv
// rtl/digitaler_filter_pkg.sv - shared widths, types and accumulator sizing for digitaler_filter
package digitaler_filter_pkg;
   localparam int DATA_W = 8;
   localparam int COEF_W = 8;

   typedef logic [DATA_W-1:0] sample_t;
   typedef logic [COEF_W-1:0] coef_t;

   // Full-precision sum of taps products: one 16-bit product plus headroom per doubling of taps.
   function automatic int acc_width(input int taps);
      return DATA_W + COEF_W + $clog2(taps);
   endfunction
endpackage

// File: rtl/digitaler_filter_mac.sv
// rtl/digitaler_filter_mac.sv - combinational multiply-accumulate, shift and saturate/wrap (DIGITALER_FILTER_SAT_EN)
module digitaler_filter_mac
   import digitaler_filter_pkg::*;
#(
   parameter int                      TAPS  = 4,
   parameter logic [TAPS*COEF_W-1:0]  COEF  = {TAPS{8'd64}},
   parameter int                      SHIFT = 8
) (
   input  sample_t                      x0,
   input  logic [(TAPS-1)*DATA_W-1:0]   hist,
   output sample_t                      y
);
   localparam int ACC_W = acc_width(TAPS);

   logic [ACC_W-1:0] acc;

   // hist byte k-1 holds x[n-k], weighted by coefficient slot k.
   always_comb begin
      acc = ACC_W'(COEF[COEF_W-1:0]) * ACC_W'(x0);
      for (int k = 1; k < TAPS; k++) begin
         acc = acc + ACC_W'(COEF[COEF_W*k +: COEF_W]) * ACC_W'(hist[DATA_W*(k-1) +: DATA_W]);
      end
   end

`ifdef DIGITALER_FILTER_SAT_EN
   assign y = ((acc >> SHIFT) > ACC_W'(255)) ? 8'hFF : sample_t'(acc >> SHIFT);
`else
   assign y = sample_t'(acc >> SHIFT);
`endif
endmodule

// File: rtl/digitaler_filter.sv
// rtl/digitaler_filter.sv - 8-bit unsigned FIR filter top: delay line and output register (DIGITALER_FILTER_SAT_EN)
module digitaler_filter
   import digitaler_filter_pkg::*;
#(
   parameter int                      TAPS  = 4,
   parameter logic [TAPS*COEF_W-1:0]  COEF  = {TAPS{8'd64}},
   parameter int                      SHIFT = 8
) (
   input  logic    clk,
   input  logic    rst_n,
   input  sample_t ui_in,
   output sample_t uo_out
);
   logic [(TAPS-1)*DATA_W-1:0] hist;
   sample_t                    y;

   digitaler_filter_mac #(
      .TAPS  (TAPS),
      .COEF  (COEF),
      .SHIFT (SHIFT)
   ) u_mac (
      .x0   (ui_in),
      .hist (hist),
      .y    (y)
   );

   // Byte 0 is d[1] (newest history sample); the line shifts toward higher bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist   <= '0;
         uo_out <= '0;
      end else begin
         for (int k = TAPS - 1; k >= 2; k--) begin
            hist[DATA_W*(k-1) +: DATA_W] <= hist[DATA_W*(k-2) +: DATA_W];
         end
         hist[DATA_W-1:0] <= ui_in;
         uo_out           <= y;
      end
   end
endmodule

// File: tb/tb_digitaler_filter.sv
// tb/tb_digitaler_filter.sv - directed self-checking bench for digitaler_filter (default and overflow coefficients)
module tb_digitaler_filter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out;
   logic       ovf_rst_n = 1'b0;
   logic [7:0] ovf_in = 8'h00;
   logic [7:0] ovf_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   digitaler_filter u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ui_in  (ui_in),
      .uo_out (uo_out)
   );

   digitaler_filter #(.COEF({4{8'd255}})) u_ovf (
      .clk    (clk),
      .rst_n  (ovf_rst_n),
      .ui_in  (ovf_in),
      .uo_out (ovf_out)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [7:0] v);
      ui_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      for (int i = 0; i < 4; i++) step(8'h00);
   endtask

   logic [7:0] step_exp [5];
   logic [7:0] seq_in   [4];
   logic [7:0] seq_exp  [4];
   logic [7:0] ovf_exp;

   initial begin
      step_exp = '{8'h20, 8'h40, 8'h60, 8'h80, 8'h80};
      seq_in   = '{8'h10, 8'h20, 8'h30, 8'h40};
      seq_exp  = '{8'h04, 8'h0C, 8'h18, 8'h28};
`ifdef DIGITALER_FILTER_SAT_EN
      ovf_exp = 8'hFF;
`else
      ovf_exp = 8'hF8;
`endif

      // 1: reset held with a busy input
      for (int i = 0; i < 4; i++) begin
         step((i % 2 == 0) ? 8'hFF : 8'h00);
         check("reset_hold", uo_out, 8'h00);
      end
      ui_in = 8'h00;
      #2 rst_n = 1'b1;
      ovf_rst_n = 1'b1;
      step(8'h00);
      check("reset_release", uo_out, 8'h00);

      // 2: impulse
      step(8'hFF);
      check("impulse_0", uo_out, 8'h3F);
      for (int i = 1; i < 4; i++) begin
         step(8'h00);
         check("impulse_tail", uo_out, 8'h3F);
      end
      step(8'h00);
      check("impulse_flushed", uo_out, 8'h00);

      // 3: step response
      for (int i = 0; i < 5; i++) begin
         step(8'h80);
         check("step_ramp", uo_out, step_exp[i]);
      end

      // 4: asynchronous reset between edges
      flush();
      step(8'h80);
      check("ramp_pre_0", uo_out, 8'h20);
      step(8'h80);
      check("ramp_pre_1", uo_out, 8'h40);
      #3 rst_n = 1'b0;
      #1 check("async_reset", uo_out, 8'h00);
      #1 rst_n = 1'b1;
      #1 check("async_released", uo_out, 8'h00);
      step(8'h80);
      check("ramp_restart_0", uo_out, 8'h20);
      step(8'h80);
      check("ramp_restart_1", uo_out, 8'h40);

      // 6: arbitrary sequence
      flush();
      check("seq_zero", uo_out, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(seq_in[i]);
         check("sequence", uo_out, seq_exp[i]);
      end

      // 5: overflow with maximal coefficients
      ovf_in = 8'hFF;
      @(posedge clk);
      #1 check("ovf_first", ovf_out, 8'hFE);
      for (int i = 0; i < 3; i++) @(posedge clk);
      #1 check("ovf_full", ovf_out, ovf_exp);
      @(posedge clk);
      #1 check("ovf_hold", ovf_out, ovf_exp);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
